// File: rtl/pdm_capture_ctrl.sv
// -----------------------------------------------------------------------------
// pdm_capture_ctrl
//
// Records a PDM microphone stream into a word-addressed buffer. The block
// generates the microphone clock, samples the PDM bit once per microphone
// clock period (on the falling edge of pdm_clk_o), packs WORD_W bits MSB-first
// and offers each completed word to the buffer with a valid/ready handshake.
//
// Optional feature (compile-time macro):
//   PDM_CAPTURE_WRAP_EN  - defined:   buffer is circular; the address wraps to
//                                     0 after MAX_WORDS-1 and capture continues
//                                     until stop_i.
//                          undefined: a handshake at MAX_WORDS-1 fills the
//                                     buffer and ends the recording.
//
// Parameters:
//   CLK_DIV    clock_i cycles per pdm_clk_o half-period (2..1048575)
//   WORD_W     PDM bits per written word (2..32)
//   MAX_WORDS  buffer depth in words, power of two >= 2
//
// Ports:
//   clock_i      in   single clock, rising edge
//   reset_i      in   synchronous active-high reset
//   start_i      in   one-cycle request to begin recording (IDLE only)
//   stop_i       in   one-cycle request to end recording (CAPTURE only)
//   pdm_data_i   in   PDM bit, already synchronous to clock_i
//   pdm_clk_o    out  registered microphone clock
//   wr_valid_o   out  word on wr_addr_o / wr_data_o is valid
//   wr_ready_i   in   buffer accepts the word this cycle
//   wr_addr_o    out  buffer word address
//   wr_data_o    out  packed PDM bits
//   busy_o       out  high in CAPTURE or FLUSH
//   done_o       out  one-cycle pulse at recording end
//   overrun_o    out  sticky: a completed word was dropped
// -----------------------------------------------------------------------------
module pdm_capture_ctrl #(
  parameter int unsigned CLK_DIV   = 100,
  parameter int unsigned WORD_W    = 16,
  parameter int unsigned MAX_WORDS = 4096,
  localparam int unsigned AW       = $clog2(MAX_WORDS)
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              pdm_data_i,
  output logic              pdm_clk_o,
  output logic              wr_valid_o,
  input  logic              wr_ready_i,
  output logic [AW-1:0]     wr_addr_o,
  output logic [WORD_W-1:0] wr_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              overrun_o
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam int unsigned BC_W  = $clog2(WORD_W);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [BC_W-1:0]  BIT_LAST  = BC_W'(WORD_W - 1);
  localparam logic [AW-1:0]    ADDR_LAST = AW'(MAX_WORDS - 1);

`ifdef PDM_CAPTURE_WRAP_EN
  localparam logic WRAP_EN = 1'b1;
`else
  localparam logic WRAP_EN = 1'b0;
`endif

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_FLUSH   = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]        state_q,   state_d;
  logic [DIV_W-1:0]  div_q,     div_d;
  logic              pdm_clk_q, pdm_clk_d;
  logic [BC_W-1:0]   bitcnt_q,  bitcnt_d;
  // Holds only the WORD_W-1 already-sampled bits; the last bit of a word
  // comes straight from pdm_data_i when the word completes.
  logic [WORD_W-2:0] shift_q,   shift_d;
  logic              valid_q,   valid_d;
  logic [WORD_W-1:0] data_q,    data_d;
  logic [AW-1:0]     addr_q,    addr_d;
  logic              overrun_q, overrun_d;

  logic              handshake;
  logic              full_hit;
  logic              div_wrap;
  logic              sample;
  logic              word_done;
  logic [WORD_W-1:0] word_next;

  assign handshake = valid_q & wr_ready_i;
  assign full_hit  = handshake & (addr_q == ADDR_LAST) & ~WRAP_EN;
  assign div_wrap  = (div_q == DIV_LAST);
  // Sample on the edge where pdm_clk_o falls (wrap while currently high).
  assign sample    = (state_q == S_CAPTURE) & div_wrap & pdm_clk_q;
  assign word_next = {shift_q, pdm_data_i};
  assign word_done = sample & (bitcnt_q == BIT_LAST);

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    pdm_clk_d = pdm_clk_q;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    valid_d   = valid_q;
    data_d    = data_q;
    addr_d    = addr_q;
    overrun_d = overrun_q;

    // Handshake retires the current word; a word loading in the same cycle
    // (below) re-asserts valid at the already-advanced address.
    if (handshake) begin
      addr_d  = addr_q + AW'(1);
      valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d   = S_CAPTURE;
          addr_d    = '0;
          bitcnt_d  = '0;
          shift_d   = '0;
          div_d     = '0;
          overrun_d = 1'b0;
          pdm_clk_d = 1'b0;
        end
      end

      S_CAPTURE: begin
        if (div_wrap) begin
          div_d     = '0;
          pdm_clk_d = ~pdm_clk_q;
        end else begin
          div_d = div_q + DIV_W'(1);
        end

        if (sample) begin
          if (word_done) begin
            bitcnt_d = '0;
            shift_d  = '0;
            if (full_hit) begin
              // Buffer just filled: nowhere to put this word.
              overrun_d = 1'b1;
            end else if (!valid_q || wr_ready_i) begin
              data_d  = word_next;
              valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            bitcnt_d = bitcnt_q + BC_W'(1);
            shift_d  = word_next[WORD_W-2:0];
          end
        end

        // Partial word is abandoned; a word completing this cycle was
        // already loaded above and drains in FLUSH.
        if (stop_i || full_hit) begin
          state_d   = S_FLUSH;
          div_d     = '0;
          pdm_clk_d = 1'b0;
        end
      end

      S_FLUSH: begin
        if (!valid_q) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      pdm_clk_q <= 1'b0;
      bitcnt_q  <= '0;
      shift_q   <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      addr_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      pdm_clk_q <= pdm_clk_d;
      bitcnt_q  <= bitcnt_d;
      shift_q   <= shift_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      addr_q    <= addr_d;
      overrun_q <= overrun_d;
    end
  end

  assign pdm_clk_o  = pdm_clk_q;
  assign wr_valid_o = valid_q;
  assign wr_addr_o  = addr_q;
  assign wr_data_o  = data_q;
  assign busy_o     = (state_q == S_CAPTURE) || (state_q == S_FLUSH);
  assign done_o     = (state_q == S_DONE);
  assign overrun_o  = overrun_q;

endmodule

// File: tb/tb_pdm_capture_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pdm_capture_ctrl
//
// Bench for pdm_capture_ctrl with CLK_DIV=2, WORD_W=4, MAX_WORDS=4. Expected
// writes are queued as PDM bits are driven and compared when the DUT performs
// a handshake. Build with PDM_CAPTURE_WRAP_EN to exercise the circular mode.
// -----------------------------------------------------------------------------
module tb_pdm_capture_ctrl;

  localparam int unsigned CLK_DIV   = 2;
  localparam int unsigned WORD_W    = 4;
  localparam int unsigned MAX_WORDS = 4;

  logic       clock_i = 1'b0;
  logic       reset_i;
  logic       start_i;
  logic       stop_i;
  logic       pdm_data_i;
  logic       pdm_clk_o;
  logic       wr_valid_o;
  logic       wr_ready_i;
  logic [1:0] wr_addr_o;
  logic [3:0] wr_data_o;
  logic       busy_o;
  logic       done_o;
  logic       overrun_o;

  always #5 clock_i = ~clock_i;

  pdm_capture_ctrl #(
    .CLK_DIV  (CLK_DIV),
    .WORD_W   (WORD_W),
    .MAX_WORDS(MAX_WORDS)
  ) dut (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .start_i   (start_i),
    .stop_i    (stop_i),
    .pdm_data_i(pdm_data_i),
    .pdm_clk_o (pdm_clk_o),
    .wr_valid_o(wr_valid_o),
    .wr_ready_i(wr_ready_i),
    .wr_addr_o (wr_addr_o),
    .wr_data_o (wr_data_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .overrun_o (overrun_o)
  );

  typedef struct packed {
    logic [1:0] addr;
    logic [3:0] data;
  } wr_t;

  typedef struct {
    logic [3:0] bits;   // PDM bits driven, MSB first
    logic [1:0] addr;   // expected write address
  } vec_t;

  int  checks    = 0;
  int  failures  = 0;
  int  hs_count  = 0;
  int  done_count = 0;
  wr_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [1:0] a, input logic [3:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  // Inputs are already set for the coming edge; a handshake seen now
  // completes at that edge.
  task automatic tick();
    wr_t e;
    if (!reset_i && wr_valid_o && wr_ready_i) begin
      hs_count++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: actual addr=%0d data=0x%0h required none",
                 wr_addr_o, wr_data_o);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", 32'(wr_addr_o), 32'(e.addr));
        chk("wr_data", 32'(wr_data_o), 32'(e.data));
      end
    end
    @(posedge clock_i);
    #1;
    if (done_o) done_count++;
  endtask

  task automatic start_rec(input logic with_stop);
    start_i = 1'b1;
    stop_i  = with_stop;
    tick();
    start_i = 1'b0;
    stop_i  = 1'b0;
  endtask

  // Each bit is held for one full pdm_clk_o period so that the falling
  // edge of pdm_clk_o lands on the last of the four edges.
  task automatic feed_bits(input logic [3:0] w, input int nbits, input logic chkclk);
    logic [3:0] clk_pat;
    clk_pat = 4'b0110;
    for (int b = 3; b > 3 - nbits; b--) begin
      pdm_data_i = w[b];
      for (int j = 0; j < 4; j++) begin
        tick();
        if (chkclk) chk("pdm_clk_phase", 32'(pdm_clk_o), 32'(clk_pat[j]));
      end
    end
  endtask

  task automatic wait_done(input int max_cycles);
    int n;
    n = 0;
    while (!done_o && n < max_cycles) begin
      tick();
      n++;
    end
    chk("done_reached", 32'(done_o), 32'd1);
  endtask

  vec_t tbl[4];

  initial begin
    tbl[0].bits = 4'hB; tbl[0].addr = 2'd0;
    tbl[1].bits = 4'h6; tbl[1].addr = 2'd1;
    tbl[2].bits = 4'h1; tbl[2].addr = 2'd2;
    tbl[3].bits = 4'hE; tbl[3].addr = 2'd3;

    reset_i    = 1'b1;
    start_i    = 1'b0;
    stop_i     = 1'b0;
    pdm_data_i = 1'b0;
    wr_ready_i = 1'b0;
    repeat (3) tick();
    chk("rst_pdm_clk", 32'(pdm_clk_o), 32'd0);
    chk("rst_valid",   32'(wr_valid_o), 32'd0);
    chk("rst_addr",    32'(wr_addr_o), 32'd0);
    chk("rst_data",    32'(wr_data_o), 32'd0);
    chk("rst_busy",    32'(busy_o), 32'd0);
    chk("rst_done",    32'(done_o), 32'd0);
    chk("rst_overrun", 32'(overrun_o), 32'd0);
    reset_i = 1'b0;
    tick();

    // Full recording: four words, ready always high.
    hs_count   = 0;
    done_count = 0;
    wr_ready_i = 1'b1;
    start_rec(1'b0);
    chk("t1_busy", 32'(busy_o), 32'd1);
    for (int i = 0; i < 4; i++) begin
      expect_wr(tbl[i].addr, tbl[i].bits);
      feed_bits(tbl[i].bits, 4, (i == 0));
    end
`ifdef PDM_CAPTURE_WRAP_EN
    expect_wr(2'd0, 4'h5);
    feed_bits(4'h5, 4, 1'b0);
    tick();
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    wait_done(20);
    repeat (4) tick();
    chk("t1_handshakes", 32'(hs_count), 32'd5);
`else
    wait_done(20);
    repeat (4) tick();
    chk("t1_handshakes", 32'(hs_count), 32'd4);
`endif
    chk("t1_done_pulses", 32'(done_count), 32'd1);
    chk("t1_pdm_clk_idle", 32'(pdm_clk_o), 32'd0);
    chk("t1_busy_idle", 32'(busy_o), 32'd0);
    chk("t1_sb_empty", 32'(sb.size()), 32'd0);

    // Overrun: second word completes while the first is still pending.
    wr_ready_i = 1'b0;
    start_rec(1'b0);
    expect_wr(2'd0, 4'h9);
    feed_bits(4'h9, 4, 1'b0);
    chk("t2_valid_first", 32'(wr_valid_o), 32'd1);
    chk("t2_no_overrun_yet", 32'(overrun_o), 32'd0);
    feed_bits(4'h3, 4, 1'b0);
    chk("t2_overrun", 32'(overrun_o), 32'd1);
    chk("t2_held_addr", 32'(wr_addr_o), 32'd0);
    chk("t2_held_data", 32'(wr_data_o), 32'h9);
    chk("t2_held_valid", 32'(wr_valid_o), 32'd1);
    wr_ready_i = 1'b1;
    tick();
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    wait_done(10);
    tick();
    chk("t2_overrun_sticky", 32'(overrun_o), 32'd1);
    chk("t2_sb_empty", 32'(sb.size()), 32'd0);

    // Early stop with a partial word; start+stop together counts as start.
    hs_count = 0;
    start_rec(1'b1);
    chk("t3_start_wins", 32'(busy_o), 32'd1);
    chk("t3_overrun_cleared", 32'(overrun_o), 32'd0);
    feed_bits(4'hC, 2, 1'b0);
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    chk("t3_flush_busy", 32'(busy_o), 32'd1);
    chk("t3_flush_done", 32'(done_o), 32'd0);
    tick();
    chk("t3_done_pulse", 32'(done_o), 32'd1);
    chk("t3_done_busy", 32'(busy_o), 32'd0);
    tick();
    chk("t3_done_drop", 32'(done_o), 32'd0);
    chk("t3_no_write", 32'(hs_count), 32'd0);
    chk("t3_valid_low", 32'(wr_valid_o), 32'd0);

    // Reset while a word is pending, with every other input asserted.
    wr_ready_i = 1'b0;
    start_rec(1'b0);
    feed_bits(4'hC, 4, 1'b0);
    chk("t4_pending", 32'(wr_valid_o), 32'd1);
    reset_i    = 1'b1;
    start_i    = 1'b1;
    stop_i     = 1'b1;
    wr_ready_i = 1'b1;
    tick();
    chk("t4_valid",   32'(wr_valid_o), 32'd0);
    chk("t4_addr",    32'(wr_addr_o), 32'd0);
    chk("t4_data",    32'(wr_data_o), 32'd0);
    chk("t4_pdm_clk", 32'(pdm_clk_o), 32'd0);
    chk("t4_busy",    32'(busy_o), 32'd0);
    chk("t4_done",    32'(done_o), 32'd0);
    chk("t4_overrun", 32'(overrun_o), 32'd0);
    reset_i = 1'b0;
    start_i = 1'b0;
    stop_i  = 1'b0;
    tick();
    chk("t4_idle_busy", 32'(busy_o), 32'd0);
    chk("t4_sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
